// File: rtl/ib_uart_tx.sv
// IB meter byte to UART bridge: 4-phase handshake into a small FIFO,
// drained by an 8N1 serializer clocked at CLK_DIV system clocks per bit.
module ib_uart_tx #(
    parameter int CLK_DIV    = 833,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_data_available,
    output logic                          tx_ack,
    output logic                          uart_txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic {H_IDLE, H_ACK} hs_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    logic                avail_meta;
    logic                avail_s;
    hs_state_t           hs_state;
    ser_state_t          ser_state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   shift;
    logic [2:0]          bit_idx;
    logic [CNT_W-1:0]    baud_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                wr_en;
    logic                rd_en;
    logic                bit_end;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign wr_en      = (hs_state == H_IDLE) && avail_s && !fifo_full;
    assign rd_en      = (ser_state == S_IDLE) && !fifo_empty;
    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign busy       = (ser_state != S_IDLE) || !fifo_empty;

    // rx_data_available comes from the meter's clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            avail_meta <= 1'b0;
            avail_s    <= 1'b0;
        end else begin
            avail_meta <= rx_data_available;
            avail_s    <= avail_meta;
        end
    end

    // One write per avail_s assertion: H_ACK blocks further writes until release
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state <= H_IDLE;
            tx_ack   <= 1'b0;
        end else begin
            case (hs_state)
                H_IDLE: begin
                    if (wr_en) begin
                        tx_ack   <= 1'b1;
                        hs_state <= H_ACK;
                    end
                end
                H_ACK: begin
                    if (!avail_s) begin
                        tx_ack   <= 1'b0;
                        hs_state <= H_IDLE;
                    end
                end
                default: hs_state <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Shift register drops the sent LSB each bit, so shift[0] is always the next bit
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_state <= S_IDLE;
            uart_txd  <= 1'b1;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            case (ser_state)
                S_IDLE: begin
                    if (rd_en) begin
                        shift     <= mem[rd_ptr];
                        uart_txd  <= 1'b0;
                        baud_cnt  <= '0;
                        ser_state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        uart_txd  <= shift[0];
                        shift     <= {1'b0, shift[DATA_W-1:1]};
                        bit_idx   <= '0;
                        ser_state <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd  <= 1'b1;
                            ser_state <= S_STOP;
                        end else begin
                            uart_txd <= shift[0];
                            shift    <= {1'b0, shift[DATA_W-1:1]};
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        ser_state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: ser_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ib_uart_tx.sv
// Bench for ib_uart_tx: handshake driver, UART line decoder and an in-order
// byte scoreboard, with a short bit period to keep frames cheap.
module tb_ib_uart_tx;
    localparam int D     = 16;
    localparam int FD    = 4;
    localparam int FRAME = 10 * D;
    localparam int TMO   = 30 * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_available = 1'b0;
    logic       tx_ack;
    logic       uart_txd;
    logic [$clog2(FD):0] fifo_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int fstart[$];
    logic [7:0] exp_q[$];
    logic [9:0] last_pat = '0;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] pat;
    } vec_t;
    vec_t vecs [6];

    ib_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_data_available(rx_data_available),
        .tx_ack(tx_ack),
        .uart_txd(uart_txd),
        .fifo_count(fifo_count),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation still running at cycle %0d, required to end", cyc);
        $fatal(1, "watchdog");
    end

    // Line decoder: a frame is 10 windows of D clocks, each window must be constant
    initial begin : line_monitor
        logic       prev;
        logic [9:0] pat;
        logic [7:0] e;
        bit         ok;
        bit         abort;
        int         t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev === 1'b1 && uart_txd === 1'b0) begin
                t0 = cyc; pat = '0; ok = 1'b1; abort = 1'b0;
                for (int i = 1; i < FRAME && !abort; i++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    else if (i % D == 0) pat[i / D] = uart_txd;
                    else if (uart_txd !== pat[i / D]) ok = 1'b0;
                end
                if (!abort) begin
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL bit_width: frame at cycle %0d has a bit not %0d clk constant (pattern %b)", t0, D, pat);
                    end
                    checks++;
                    if (pat[9] !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: got %b, required 1", pat[9]);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got byte %h, required no frame", pat[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        if (pat[8:1] !== e) begin
                            errors++;
                            $display("FAIL frame_data: got %h, required %h", pat[8:1], e);
                        end
                    end
                    last_pat = pat;
                    fstart.push_back(t0);
                    frames++;
                end
            end
            prev = uart_txd;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit chk_lat, output int ack_cyc);
        int n;
        rx_data = b;
        rx_data_available = 1'b1;
        n = 0;
        while (tx_ack !== 1'b1 && n < TMO) begin tick(1); n++; end
        ack_cyc = cyc;
        if (tx_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_timeout: tx_ack=%b after %0d clk, required 1", tx_ack, n);
        end else begin
            exp_q.push_back(b);
            if (chk_lat) begin
                checks++;
                if (n > 3) begin
                    errors++;
                    $display("FAIL ack_latency: got %0d clk, required <= 3", n);
                end
            end
        end
        rx_data = 8'($urandom);
        tick(hold);
        rx_data_available = 1'b0;
        n = 0;
        while (tx_ack !== 1'b0 && n < TMO) begin tick(1); n++; end
        checks++;
        if (n > 3) begin
            errors++;
            $display("FAIL ack_release: tx_ack low after %0d clk, required <= 3", n);
        end
    endtask

    task automatic wait_frames(input int n, input int bound, input string name);
        int k;
        k = 0;
        while (frames < n && k < bound) begin tick(1); k++; end
        if (frames < n) begin
            checks++; errors++;
            $display("FAIL %s: got %0d frames, required %0d", name, frames, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 12 * FRAME) begin tick(1); k++; end
        if (busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL %s: busy=%b, required 0", name, busy);
        end
        tick(2);
    endtask

    initial begin
        int a;
        int e0;
        int f0;
        int s0;
        int n;
        int trans;
        logic p;

        vecs[0] = '{data: 8'hA5, pat: 10'b1101001010};
        vecs[1] = '{data: 8'h00, pat: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, pat: 10'b1111111110};
        vecs[3] = '{data: 8'h01, pat: 10'b1000000010};
        vecs[4] = '{data: 8'h80, pat: 10'b1100000000};
        vecs[5] = '{data: 8'h3C, pat: 10'b1001111000};

        tick(4);
        check("reset_tx_ack", int'(tx_ack), 0);
        check("reset_uart_txd", int'(uart_txd), 1);
        check("reset_fifo_count", int'(fifo_count), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick(2);

        // Single bytes against hand-derived line patterns
        foreach (vecs[i]) begin
            f0 = frames;
            send_byte(vecs[i].data, 4, 1'b1, a);
            wait_frames(f0 + 1, 2 * FRAME, "single_frame");
            checks++;
            if (last_pat !== vecs[i].pat) begin
                errors++;
                $display("FAIL line_pattern[%0d]: got %b, required %b", i, last_pat, vecs[i].pat);
            end
            wait_idle("single_idle");
        end

        // Available held for several frame times still sends exactly one byte
        f0 = frames;
        send_byte(8'h5A, 5 * FRAME, 1'b1, a);
        tick(2 * FRAME);
        check("hold_one_frame", frames, f0 + 1);
        check("hold_fifo_empty", int'(fifo_count), 0);
        wait_idle("hold_idle");

        // Backpressure: byte 1 leaves the FIFO at once, bytes 2..5 fill it, byte 6 waits
        f0 = frames;
        s0 = fstart.size();
        send_byte(8'h01, 2, 1'b1, e0);
        for (int k = 2; k <= 5; k++) send_byte(8'(k), 2, 1'b1, a);
        check("bp_fifo_full", int'(fifo_count), FD);
        rx_data_available = 1'b0;
        tick(6);
        check("bp_ack_low_while_full", int'(tx_ack), 0);
        send_byte(8'h06, 2, 1'b0, a);
        check("bp_ack_after_first_frame", int'(a - e0 > FRAME), 1);
        wait_frames(f0 + 6, 8 * FRAME, "bp_frames");
        if (fstart.size() >= s0 + 6) begin
            for (int k = 0; k < 5; k++)
                check("bp_frame_gap", fstart[s0 + k + 1] - fstart[s0 + k], FRAME + 1);
        end
        wait_idle("bp_idle");

        // Back-to-back: count steps 2 -> 1 -> 0 at each start bit
        f0 = frames;
        send_byte(8'h11, 2, 1'b1, a);
        send_byte(8'h22, 2, 1'b1, a);
        send_byte(8'h33, 2, 1'b1, a);
        check("b2b_count_two", int'(fifo_count), 2);
        n = 0;
        while (fifo_count == 2 && n < 2 * FRAME) begin tick(1); n++; end
        check("b2b_count_one", int'(fifo_count), 1);
        check("b2b_start_bit", int'(uart_txd), 0);
        n = 0;
        while (fifo_count == 1 && n < 2 * FRAME) begin tick(1); n++; end
        check("b2b_count_zero", int'(fifo_count), 0);
        wait_frames(f0 + 3, 4 * FRAME, "b2b_frames");
        wait_idle("b2b_idle");

        // Write lands on the same edge the serializer pops, with one byte buffered
        f0 = frames;
        rx_data = 8'h44;
        rx_data_available = 1'b1;
        n = 0;
        while (uart_txd !== 1'b0 && n < TMO) begin tick(1); n++; end
        e0 = cyc;
        check("sim_first_start", int'(uart_txd), 0);
        exp_q.push_back(8'h44);
        rx_data_available = 1'b0;
        tick(4);
        send_byte(8'h55, 1, 1'b1, a);
        while (cyc < e0 + FRAME - 2) tick(1);
        rx_data = 8'h66;
        rx_data_available = 1'b1;
        while (cyc < e0 + FRAME + 1) tick(1);
        check("sim_count_stays_one", int'(fifo_count), 1);
        check("sim_ack", int'(tx_ack), 1);
        check("sim_second_start", int'(uart_txd), 0);
        exp_q.push_back(8'h66);
        rx_data_available = 1'b0;
        tick(4);
        wait_frames(f0 + 3, 4 * FRAME, "sim_frames");
        wait_idle("sim_idle");

        // Reset during data bit 3 of 8'hFF with another byte buffered
        send_byte(8'hFF, 2, 1'b1, a);
        e0 = a + 1;
        send_byte(8'h77, 2, 1'b1, n);
        check("rst_count_before", int'(fifo_count), 1);
        while (cyc < e0 + 4 * D + D / 2) tick(1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_uart_txd", int'(uart_txd), 1);
        check("rst_mid_fifo_count", int'(fifo_count), 0);
        check("rst_mid_tx_ack", int'(tx_ack), 0);
        rst = 1'b0;
        exp_q.delete();
        trans = 0;
        p = uart_txd;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick(1);
            if (uart_txd !== p) trans++;
            p = uart_txd;
        end
        check("rst_no_transitions", trans, 0);
        check("rst_busy", int'(busy), 0);

        // Available still high across reset is taken again once resynchronized
        f0 = frames;
        rx_data = 8'h99;
        rx_data_available = 1'b1;
        n = 0;
        while (tx_ack !== 1'b1 && n < TMO) begin tick(1); n++; end
        tick(5);
        rst = 1'b1;
        tick(1);
        check("rst_hold_tx_ack", int'(tx_ack), 0);
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        while (tx_ack !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("rst_reaccept_latency_ok", int'(tx_ack === 1'b1 && n <= 3), 1);
        exp_q.push_back(8'h99);
        rx_data_available = 1'b0;
        tick(4);
        wait_frames(f0 + 1, 2 * FRAME, "rst_reaccept_frame");
        wait_idle("rst_reaccept_idle");

        // Random bytes, holds and gaps; order checked by the line decoder
        f0 = frames;
        for (int k = 0; k < 16; k++) begin
            send_byte(8'($urandom), int'($urandom_range(0, 12)), 1'b0, a);
            tick(int'($urandom_range(0, FRAME)));
        end
        wait_frames(f0 + 16, 20 * FRAME, "rand_frames");
        wait_idle("rand_idle");
        check("rand_all_sent", exp_q.size(), 0);
        check("final_fifo_count", int'(fifo_count), 0);
        check("final_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
